i2c_target_rx: RTL and testbench

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_target_rx.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// I2C target (slave) with a byte-wide write sink and read source.
// SCL/SDA are synchronized into clk, and every bus event is derived from the
// synchronized samples. A single FSM tracks the byte/ACK framing and drives
// the open-drain pull-down enable for ACK slots and read data.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | bus free or not yet seen a START; nothing driven
// S_ADDR     | shifting in the address byte after START
// S_ADDR_ACK | address matched; ACK slot (read also fetches first byte)
// S_WR_DATA  | shifting in a write data byte
// S_WR_ACK   | ACK slot after a write byte
// S_RD_DATA  | driving read data bits, MSB first
// S_RD_ACK   | SDA released, sampling the master's ACK/NACK
// S_IGNORE   | not addressed or read ended; wait for START/STOP
module i2c_target_rx #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] i_rdata,
  output logic       o_rdata_req,
  output logic [7:0] o_wdata,
  output logic       o_wdata_dv,
  output logic       o_addr_match,
  output logic       o_start_det,
  output logic       o_stop_det,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] tx_q;
  logic       rw_q;
  logic       ack_phase_q;
  logic       first_bit_q;
  logic       sda_oe_q;
  logic       rdata_req_q;
  logic [7:0] wdata_q;
  logic       wdata_dv_q;
  logic       addr_match_q;
  logic       start_det_q;
  logic       stop_det_q;
  logic       busy_q;

  logic       scl_high, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte_d;
  logic       addr_hit;

  // Two-flop synchronizers followed by one edge-history flop per line.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  assign scl_high  = scl_sync_q & scl_hist_q;
  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_ev  = scl_high & sda_hist_q & ~sda_sync_q;
  assign stop_ev   = scl_high & ~sda_hist_q & sda_sync_q;
  assign rx_byte_d = {shift_q[6:0], sda_sync_q};
  // General call and the 10-bit prefix never match, even if SLV_ADDR is set to one.
  assign addr_hit  = (rx_byte_d[7:1] == SLV_ADDR) && (rx_byte_d[7:1] != 7'h00) &&
                     (rx_byte_d[7:3] != 5'b11110);

  // Protocol FSM; START/STOP override any bit activity in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      tx_q         <= 8'h00;
      rw_q         <= 1'b0;
      ack_phase_q  <= 1'b0;
      first_bit_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      rdata_req_q  <= 1'b0;
      wdata_q      <= 8'h00;
      wdata_dv_q   <= 1'b0;
      addr_match_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      wdata_dv_q  <= 1'b0;
      rdata_req_q <= 1'b0;
      if (start_ev) begin
        state_q      <= S_ADDR;
        bit_cnt_q    <= 3'd0;
        shift_q      <= 8'h00;
        sda_oe_q     <= 1'b0;
        ack_phase_q  <= 1'b0;
        first_bit_q  <= 1'b0;
        addr_match_q <= 1'b0;
        busy_q       <= 1'b1;
        start_det_q  <= 1'b1;
      end else if (stop_ev) begin
        state_q      <= S_IDLE;
        sda_oe_q     <= 1'b0;
        addr_match_q <= 1'b0;
        busy_q       <= 1'b0;
        stop_det_q   <= 1'b1;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (addr_hit) begin
                  state_q      <= S_ADDR_ACK;
                  rw_q         <= rx_byte_d[0];
                  addr_match_q <= 1'b1;
                  ack_phase_q  <= 1'b0;
                  rdata_req_q  <= rx_byte_d[0];
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                shift_q     <= 8'h00;
                if (rw_q) begin
                  // The ACK-release edge is also the edge that presents the first read bit.
                  state_q     <= S_RD_DATA;
                  sda_oe_q    <= ~tx_q[7];
                  tx_q        <= {tx_q[6:0], 1'b0};
                  bit_cnt_q   <= 3'd1;
                  first_bit_q <= 1'b0;
                end else begin
                  state_q   <= S_WR_DATA;
                  sda_oe_q  <= 1'b0;
                  bit_cnt_q <= 3'd0;
                end
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                wdata_q     <= rx_byte_d;
                wdata_dv_q  <= 1'b1;
                state_q     <= S_WR_ACK;
                ack_phase_q <= 1'b0;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                sda_oe_q    <= 1'b0;
                ack_phase_q <= 1'b0;
                state_q     <= S_WR_DATA;
                bit_cnt_q   <= 3'd0;
                shift_q     <= 8'h00;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              // Count wraps to 0 once all eight bits are out; the next fall releases SDA.
              if (first_bit_q || (bit_cnt_q != 3'd0)) begin
                sda_oe_q    <= ~tx_q[7];
                tx_q        <= {tx_q[6:0], 1'b0};
                bit_cnt_q   <= bit_cnt_q + 3'd1;
                first_bit_q <= 1'b0;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RD_ACK;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_sync_q) begin
                rdata_req_q <= 1'b1;
                state_q     <= S_RD_DATA;
                bit_cnt_q   <= 3'd0;
                first_bit_q <= 1'b1;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
        // Read data is taken in the cycle the request pulse is visible.
        if (rdata_req_q) begin
          tx_q <= i_rdata;
        end
      end
    end
  end

  assign sda_oe       = sda_oe_q;
  assign o_rdata_req  = rdata_req_q;
  assign o_wdata      = wdata_q;
  assign o_wdata_dv   = wdata_dv_q;
  assign o_addr_match = addr_match_q;
  assign o_start_det  = start_det_q;
  assign o_stop_det   = stop_det_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bus-level master drives SCL/SDA, the target's
// pull-down is wired-ANDed onto SDA, and a transaction-level model (expected
// write-byte queue, address-match rule, read-byte list) is checked against it.
module tb_i2c_target_rx;

  localparam int Q = 6;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] i_rdata;
  logic       o_rdata_req;
  logic [7:0] o_wdata;
  logic       o_wdata_dv;
  logic       o_addr_match;
  logic       o_start_det;
  logic       o_stop_det;
  logic       o_busy;

  assign sda_in = sda_m & ~sda_oe;

  i2c_target_rx #(.SLV_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .i_rdata(i_rdata), .o_rdata_req(o_rdata_req), .o_wdata(o_wdata),
    .o_wdata_dv(o_wdata_dv), .o_addr_match(o_addr_match),
    .o_start_det(o_start_det), .o_stop_det(o_stop_det), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int dv_cnt = 0, req_cnt = 0, start_cnt = 0, stop_cnt = 0, quiet_viol = 0;
  bit quiet = 1'b0;
  logic [7:0] rd_vals[4];
  int rd_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model rule: only the configured 7-bit address (never 0, never a 10-bit prefix) is ACKed.
  function automatic bit addr_acked(input logic [7:0] b);
    return (b[7:1] == 7'h50) && (b[7:1] != 7'h00) && (b[7:3] != 5'b11110);
  endfunction

  // Every cycle: write-byte stream against the model queue, pulse counters, quiet-bus check.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wdata_dv) begin
        dv_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wdata_dv_unexpected: got 0x%02h expected no pulse", o_wdata);
        end else begin
          check("wdata_stream", o_wdata, exp_q.pop_front());
        end
      end
      if (o_start_det) start_cnt++;
      if (o_stop_det) stop_cnt++;
      if (quiet && sda_oe) quiet_viol++;
    end
  end

  // Read-data responder: present the next byte after each request is consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_rdata_req) begin
        req_cnt++;
        @(posedge clk);
        #1;
        rd_idx++;
        i_rdata = rd_vals[rd_idx & 3];
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input bit b, output bit sampled);
    sda_m = b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sampled = sda_in;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  // Master write of one byte; the data bits must come back unaltered on the bus.
  task automatic wr(input logic [7:0] b, input bit exp_ack, input string nm);
    logic [7:0] echo;
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], s);
      echo[i] = s;
    end
    clock_bit(1'b1, s);
    check({nm, "_echo"}, echo, b);
    check({nm, "_ack"}, {31'd0, ~s}, {31'd0, exp_ack});
  endtask

  task automatic rd(input bit master_ack, output logic [7:0] got);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      got[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  int dv0, req0, st0, sp0;
  logic [7:0] got;
  bit s;

  task automatic snap();
    dv0 = dv_cnt; req0 = req_cnt; st0 = start_cnt; sp0 = stop_cnt;
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    rd_vals[0] = 8'h3C; rd_vals[1] = 8'hC3; rd_vals[2] = 8'h00; rd_vals[3] = 8'h00;
    i_rdata = rd_vals[0];
    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", o_busy, 0);
    check("rst_addr_match", o_addr_match, 0);
    check("rst_wdata", o_wdata, 8'h00);
    check("rst_pulses", {o_wdata_dv, o_rdata_req, o_start_det, o_stop_det}, 4'b0000);
    rst = 1'b0;
    wait_clk(10);

    // Model self-pins
    check("model_addr_50W", addr_acked(8'hA0), 1);
    check("model_addr_51W", addr_acked(8'hA2), 0);
    check("model_general_call", addr_acked(8'h00), 0);

    // Write 0x50+W, 0xA5, STOP
    snap();
    bus_start();
    check("wr_busy_after_start", o_busy, 1);
    wr(8'hA0, addr_acked(8'hA0), "wr_addr");
    check("wr_addr_match", o_addr_match, 1);
    exp_q.push_back(8'hA5);
    wr(8'hA5, 1'b1, "wr_data");
    bus_stop();
    check("wr_wdata_A5", o_wdata, 8'hA5);
    check("wr_dv_count", dv_cnt - dv0, 1);
    check("wr_start_count", start_cnt - st0, 1);
    check("wr_stop_count", stop_cnt - sp0, 1);
    check("wr_busy_after_stop", o_busy, 0);
    check("wr_match_after_stop", o_addr_match, 0);

    // Address mismatch 0x51+W
    snap();
    quiet = 1'b1;
    bus_start();
    wr(8'hA2, addr_acked(8'hA2), "nm_addr");
    check("nm_addr_match", o_addr_match, 0);
    wr(8'h55, 1'b0, "nm_data");
    bus_stop();
    quiet = 1'b0;
    check("nm_dv_count", dv_cnt - dv0, 0);
    check("nm_quiet", quiet_viol, 0);

    // Read 0x50+R: 0x3C (ACK), 0xC3 (NACK), then ignored until STOP
    snap();
    rd_idx = 0;
    i_rdata = rd_vals[0];
    bus_start();
    wr(8'hA1, addr_acked(8'hA1), "rd_addr");
    rd(1'b1, got);
    check("rd_byte0_3C", got, 8'h3C);
    rd(1'b0, got);
    check("rd_byte1_C3", got, 8'hC3);
    quiet = 1'b1;
    clock_bit(1'b1, s);
    check("rd_ignore_sda", s, 1);
    bus_stop();
    quiet = 1'b0;
    check("rd_req_count", req_cnt - req0, 2);
    check("rd_dv_count", dv_cnt - dv0, 0);
    check("rd_quiet", quiet_viol, 0);

    // Repeated START after 4 bits of a write byte
    snap();
    bus_start();
    wr(8'hA0, 1'b1, "rs_addr1");
    for (int i = 0; i < 4; i++) clock_bit(i[0] ? 1'b0 : 1'b1, s);
    bus_start();
    check("rs_match_cleared", o_addr_match, 0);
    wr(8'hA0, 1'b1, "rs_addr2");
    exp_q.push_back(8'h11);
    wr(8'h11, 1'b1, "rs_data");
    bus_stop();
    check("rs_dv_count", dv_cnt - dv0, 1);
    check("rs_wdata_11", o_wdata, 8'h11);
    check("rs_start_count", start_cnt - st0, 2);

    // Reset while the target is pulling SDA in the address ACK slot
    snap();
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(i == 7 || i == 5, s);
    sda_m = 1'b1;
    check("rr_ack_driving", sda_oe, 1);
    rst = 1'b1;
    wait_clk(1);
    check("rr_sda_released", sda_oe, 0);
    wait_clk(1);
    rst = 1'b0;
    check("rr_wdata_cleared", o_wdata, 8'h00);
    check("rr_busy", o_busy, 0);
    quiet = 1'b1;
    wait_clk(Q - 2);
    scl = 1'b1;
    wait_clk(2 * Q);
    scl = 1'b0;
    wait_clk(Q);
    wr(8'hA0, 1'b0, "rr_no_start_addr");
    check("rr_no_match", o_addr_match, 0);
    bus_stop();
    check("rr_quiet", quiet_viol, 0);
    quiet = 1'b0;
    bus_start();
    wr(8'hA0, 1'b1, "rr_fresh_addr");
    exp_q.push_back(8'h77);
    wr(8'h77, 1'b1, "rr_fresh_data");
    bus_stop();
    check("rr_dv_count", dv_cnt - dv0, 1);

    // Back-to-back write of three bytes
    snap();
    bus_start();
    wr(8'hA0, 1'b1, "b2b_addr");
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(i[7:0]);
      wr(i[7:0], 1'b1, "b2b_data");
    end
    bus_stop();
    check("b2b_dv_count", dv_cnt - dv0, 3);
    check("b2b_wdata_03", o_wdata, 8'h03);
    check("b2b_queue_drained", exp_q.size(), 0);

    wait_clk(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
